// File: rtl/trace_pkg.sv
// Shared constants and types for the retire-event trace buffer.
// Provides the default sizing, the channel assignment and the packed trace entry layout.
package trace_pkg;

  localparam int TRC_NUM_CH  = 3;
  localparam int TRC_DEPTH   = 16;
  localparam int TRC_DATA_W  = 64;
  localparam int TRC_STAMP_W = 16;
  localparam int TRC_CH_W    = $clog2(TRC_NUM_CH);

  localparam logic [TRC_CH_W-1:0] TRC_CH_GPR  = TRC_CH_W'(0);
  localparam logic [TRC_CH_W-1:0] TRC_CH_HILO = TRC_CH_W'(1);
  localparam logic [TRC_CH_W-1:0] TRC_CH_MEM  = TRC_CH_W'(2);

  typedef struct packed {
    logic [TRC_CH_W-1:0]    ch;
    logic [TRC_STAMP_W-1:0] stamp;
    logic [TRC_DATA_W-1:0]  payload;
  } trace_entry_t;

endpackage

// File: rtl/trace_rr_arbiter.sv
// Round-robin single grant across NUM_CH requesters.
// The pointer holds the last winner; the search starts strictly after it.
module trace_rr_arbiter #(
  parameter int NUM_CH = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      en_i,
  input  logic [NUM_CH-1:0]         req_i,
  output logic                      gnt_valid_o,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] cand, pick;
  logic             found;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = rrPtr_q;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign gnt_valid_o = en_i && found;
  assign gnt_idx_o   = pick;
  assign rrPtr_d     = gnt_valid_o ? pick : rrPtr_q;

  // Reset and flush park the pointer on the last channel so channel 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rrPtr_q <= LAST_IDX;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/trace_event_buffer.sv
// Commit-event trace buffer: per-channel staging registers drained round-robin into a FIFO.
// Define TRACE_SIGNATURE_EN to build the running 32-bit pop signature; otherwise sig_out is 0.
module trace_event_buffer
  import trace_pkg::*;
#(
  parameter int NUM_CH  = TRC_NUM_CH,
  parameter int DEPTH   = TRC_DEPTH,
  parameter int DATA_W  = TRC_DATA_W,
  parameter int STAMP_W = TRC_STAMP_W
) (
  input  logic                      clk_50M,
  input  logic                      reset_btn,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         ev_valid,
  input  logic [NUM_CH*DATA_W-1:0]  ev_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [DATA_W-1:0]         out_payload,
  output logic [STAMP_W-1:0]        out_stamp,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [31:0]               sig_out
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);

  // Same field layout as trace_entry_t, resized to this instance's parameters.
  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [STAMP_W-1:0] stamp;
    logic [DATA_W-1:0]  payload;
  } entry_t;

  logic [STAMP_W-1:0] stamp_q;
  logic [NUM_CH-1:0]  stageValid_q, stageValid_d, stageLoad, stageDrop, stageGnt;
  logic [DATA_W-1:0]  stagePayload_q [NUM_CH];
  logic [STAMP_W-1:0] stageStamp_q [NUM_CH];
  entry_t             fifoMem_q [DEPTH];
  entry_t             headEntry;
  logic [AW-1:0]      wrPtr_q, rdPtr_q;
  logic [AW:0]        level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        dropCount_q, dropCount_d;
  logic [16:0]        dropSum;
  logic               fifoFull, push, pop, gntValid;
  logic [CH_W-1:0]    gntIdx;

  assign fifoFull  = (level_q == (AW+1)'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = gntValid;

  trace_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i       (clk_50M),
    .rst_i       (reset_btn),
    .flush_i     (clear),
    .en_i        (!clear && (!fifoFull || pop)),
    .req_i       (stageValid_q),
    .gnt_valid_o (gntValid),
    .gnt_idx_o   (gntIdx)
  );

  // A stage may refill in the same cycle it is granted; otherwise a busy stage drops.
  always_comb begin
    stageGnt  = '0;
    stageLoad = '0;
    stageDrop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stageGnt[i] = gntValid && (gntIdx == CH_W'(i));
      if (ev_valid[i] && !clear) begin
        if (!stageValid_q[i] || stageGnt[i]) stageLoad[i] = 1'b1;
        else                                 stageDrop[i] = 1'b1;
      end
    end
    stageValid_d = clear ? '0 : ((stageValid_q & ~stageGnt) | stageLoad);
  end

  always_comb begin
    dropSum = {1'b0, dropCount_q};
    for (int i = 0; i < NUM_CH; i++) begin
      dropSum = dropSum + 17'(stageDrop[i]);
    end
    dropCount_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    overflow_d  = overflow_q | (|stageDrop);
    level_d     = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (clear) begin
      dropCount_d = '0;
      overflow_d  = 1'b0;
      level_d     = '0;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      stamp_q      <= '0;
      stageValid_q <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      dropCount_q  <= '0;
    end else begin
      stamp_q      <= stamp_q + STAMP_W'(1);
      stageValid_q <= stageValid_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      dropCount_q  <= dropCount_d;
      if (clear) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + AW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      end
    end
  end

  // Datapath storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk_50M) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (stageLoad[i]) begin
        stagePayload_q[i] <= ev_payload[i*DATA_W +: DATA_W];
        stageStamp_q[i]   <= stamp_q;
      end
    end
    if (push) begin
      fifoMem_q[wrPtr_q] <= '{ch: gntIdx, stamp: stageStamp_q[gntIdx], payload: stagePayload_q[gntIdx]};
    end
  end

  assign headEntry   = fifoMem_q[rdPtr_q];
  assign out_ch      = out_valid ? headEntry.ch      : '0;
  assign out_payload = out_valid ? headEntry.payload : '0;
  assign out_stamp   = out_valid ? headEntry.stamp   : '0;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign drop_count  = dropCount_q;

`ifdef TRACE_SIGNATURE_EN
  logic [31:0] sig_q, sigFold;

  always_comb begin
    sigFold = 32'({out_stamp, out_ch});
    for (int w = 0; w < DATA_W / 32; w++) begin
      sigFold = sigFold ^ out_payload[w*32 +: 32];
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn || clear) begin
      sig_q <= '0;
    end else if (pop) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ sigFold;
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = '0;
`endif

endmodule

// File: tb/tb_trace_event_buffer.sv
// Directed self-checking bench for trace_event_buffer at its default sizing.
// Cycle 0 is the cycle right after reset is released; its stamp is 0.
module tb_trace_event_buffer;

  localparam int NUM_CH  = 3;
  localparam int DEPTH   = 16;
  localparam int DATA_W  = 64;
  localparam int STAMP_W = 16;

  logic                     clk_50M = 1'b0;
  logic                     reset_btn, clear, out_ready, out_valid, overflow;
  logic [NUM_CH-1:0]        ev_valid;
  logic [NUM_CH*DATA_W-1:0] ev_payload;
  logic [1:0]               out_ch;
  logic [DATA_W-1:0]        out_payload;
  logic [STAMP_W-1:0]       out_stamp;
  logic [4:0]               level;
  logic [15:0]              drop_count;
  logic [31:0]              sig_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] expStampQ [$];
  logic [63:0] expPayQ [$];

  trace_event_buffer #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .STAMP_W(STAMP_W)
  ) dut (
    .clk_50M     (clk_50M),
    .reset_btn   (reset_btn),
    .clear       (clear),
    .ev_valid    (ev_valid),
    .ev_payload  (ev_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_payload (out_payload),
    .out_stamp   (out_stamp),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .sig_out     (sig_out)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_50M);
    @(negedge clk_50M);
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [63:0] p0, input logic [63:0] p1,
                               input logic [63:0] p2);
    ev_valid   = valid;
    ev_payload = {p2, p1, p0};
  endtask

  task automatic applyReset();
    reset_btn = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    @(posedge clk_50M);
    @(posedge clk_50M);
    @(negedge clk_50M);
    reset_btn = 1'b0;
    cyc       = 0;
  endtask

  // ch0 fires in cycles 2..21 with out_ready low: 16 in FIFO, 1 staged, 3 dropped.
  task automatic fillOverrun();
    applyReset();
    stepTo(2);
    for (int c = 2; c <= 21; c++) begin
      applyStimulus(3'b001, {32'hA5A5_0000, 32'(c)}, 64'h0, 64'h0);
      stepCycle();
    end
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
  endtask

  logic [63:0] colPay [3];
  logic [31:0] expSig;
  int          sent, got;

  initial begin
    colPay[0] = 64'h1111_0000_0000_00A0;
    colPay[1] = 64'h2222_0000_0000_00B1;
    colPay[2] = 64'h3333_0000_0000_00C2;

    // Reset state
    applyReset();
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_ch", out_ch, 0);
    checkOutput("rst_payload", out_payload, 0);
    checkOutput("rst_stamp", out_stamp, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_drops", drop_count, 0);
    checkOutput("rst_sig", sig_out, 0);

    // Single uncontended event: in cycle 3, visible in cycle 5 for one cycle
    out_ready = 1'b1;
    stepTo(3);
    applyStimulus(3'b001, 64'h0000_001F_0000_0005, 64'h0, 64'h0);
    stepCycle();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    checkOutput("single_early_valid", out_valid, 0);
    stepCycle();
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_ch", out_ch, 0);
    checkOutput("single_payload", out_payload, 64'h0000_001F_0000_0005);
    checkOutput("single_stamp", out_stamp, 3);
    checkOutput("single_level", level, 1);
    stepCycle();
    checkOutput("single_level_after", level, 0);
    checkOutput("single_valid_after", out_valid, 0);

    // Three-way collision in cycle 10 drains as ch0, ch1, ch2 in cycles 12..14
    applyReset();
    out_ready = 1'b1;
    stepTo(10);
    applyStimulus(3'b111, colPay[0], colPay[1], colPay[2]);
    stepCycle();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    checkOutput("col_c11_valid", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("col_valid", out_valid, 1);
      checkOutput("col_ch", out_ch, 64'(k));
      checkOutput("col_payload", out_payload, colPay[k]);
      checkOutput("col_stamp", out_stamp, 10);
      checkOutput("col_level", level, 1);
    end
    stepCycle();
    checkOutput("col_empty", out_valid, 0);
    checkOutput("col_drops", drop_count, 0);
    checkOutput("col_overflow", overflow, 0);

    // Overrun then full drain of 17 consecutive stamps 2..18
    fillOverrun();
    checkOutput("ovr_level", level, 16);
    checkOutput("ovr_drops", drop_count, 3);
    checkOutput("ovr_overflow", overflow, 1);
    checkOutput("ovr_head_stamp", out_stamp, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      checkOutput("ovr_drain_valid", out_valid, 1);
      checkOutput("ovr_drain_stamp", out_stamp, 64'(2 + k));
      checkOutput("ovr_drain_payload", out_payload, {32'hA5A5_0000, 32'(2 + k)});
      stepCycle();
    end
    checkOutput("ovr_drained_valid", out_valid, 0);
    checkOutput("ovr_drained_level", level, 0);
    checkOutput("ovr_sticky_drops", drop_count, 3);

    // Clear mid-stream with 5 entries queued and a concurrent event
    fillOverrun();
    out_ready = 1'b1;
    stepTo(34);
    out_ready = 1'b0;
    checkOutput("clr_pre_level", level, 5);
    checkOutput("clr_pre_overflow", overflow, 1);
    checkOutput("clr_pre_head", out_stamp, 14);
    clear = 1'b1;
    applyStimulus(3'b111, 64'hDEAD_0000, 64'hDEAD_0001, 64'hDEAD_0002);
    stepCycle();
    clear = 1'b0;
    out_ready = 1'b1;
    applyStimulus(3'b101, 64'hC0DE_0000, 64'h0, 64'hC0DE_0002);
    checkOutput("clr_level", level, 0);
    checkOutput("clr_valid", out_valid, 0);
    checkOutput("clr_drops", drop_count, 0);
    checkOutput("clr_overflow", overflow, 0);
    stepCycle();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    checkOutput("clr_discarded", out_valid, 0);
    stepCycle();
    checkOutput("clr_post0_ch", out_ch, 0);
    checkOutput("clr_post0_stamp", out_stamp, 35);
    checkOutput("clr_post0_payload", out_payload, 64'hC0DE_0000);
    stepCycle();
    checkOutput("clr_post2_ch", out_ch, 2);
    checkOutput("clr_post2_stamp", out_stamp, 35);
    stepCycle();
    checkOutput("clr_post_empty", out_valid, 0);

    // Streaming 40 events through the FIFO with a 3-of-4 ready pattern
    applyReset();
    sent = 0;
    got  = 0;
    for (int guard = 0; guard < 200 && got < 40; guard++) begin
      if (sent < 40) begin
        applyStimulus(3'b001, {32'h5EED_0000, 32'(sent)}, 64'h0, 64'h0);
        expStampQ.push_back(16'(cyc));
        expPayQ.push_back({32'h5EED_0000, 32'(sent)});
        sent++;
      end else begin
        applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
      end
      out_ready = ((guard % 4) != 3);
      if (out_valid && out_ready) begin
        if (expStampQ.size() == 0) begin
          checkOutput("stream_unexpected", 64'(out_valid), 0);
        end else begin
          checkOutput("stream_stamp", out_stamp, expStampQ.pop_front());
          checkOutput("stream_payload", out_payload, expPayQ.pop_front());
        end
        got++;
      end
      stepCycle();
    end
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    checkOutput("stream_count", got, 40);
    checkOutput("stream_drops", drop_count, 0);
    checkOutput("stream_empty", out_valid, 0);

    // Signature after one pop: ch1, stamp 2, payload 0x00000001_00000003
    applyReset();
    out_ready = 1'b1;
    stepTo(2);
    applyStimulus(3'b010, 64'h0, 64'h0000_0001_0000_0003, 64'h0);
    stepCycle();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0);
    stepCycle();
    checkOutput("sig_entry_ch", out_ch, 1);
    checkOutput("sig_entry_stamp", out_stamp, 2);
    stepCycle();
`ifdef TRACE_SIGNATURE_EN
    // words 0x3 ^ 0x1 = 0x2; {stamp 16'h0002, ch 2'b01} = 0x9; rotl1(0) ^ 0xB
    expSig = 32'h0000_000B;
`else
    expSig = 32'h0;
`endif
    checkOutput("sig_value", sig_out, 64'(expSig));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
